// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: aligns load data, applies stall/flush rules,
// drives the regfile write port and counts committed GPR writes.
module mem_wb_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              mem_stall,
  input  logic              wb_stall,
  input  logic              mem_valid,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_waddr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic [2:0]        mem_load_op,
  input  logic [1:0]        mem_addr_lo,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [DATA_W-1:0] mem_rt_data,
  output logic              wb_we,
  output logic [ADDR_W-1:0] wb_waddr,
  output logic [DATA_W-1:0] wb_wdata,
  output logic              wb_misalign,
  output logic [31:0]       wb_commit_cnt
);

  localparam logic [2:0] OP_NONE = 3'd0;
  localparam logic [2:0] OP_LB   = 3'd1;
  localparam logic [2:0] OP_LBU  = 3'd2;
  localparam logic [2:0] OP_LH   = 3'd3;
  localparam logic [2:0] OP_LHU  = 3'd4;
  localparam logic [2:0] OP_LW   = 3'd5;
  localparam logic [2:0] OP_LWL  = 3'd6;
  localparam logic [2:0] OP_LWR  = 3'd7;

  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              mis_q, mis_d;
  logic [31:0]       cnt_q, cnt_d;

  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [DATA_W-1:0] aligned;
  logic              misaligned;

  // Big-endian lanes: address offset 0 is the most significant byte.
  always_comb begin
    byte_sel = mem_rdata[31:24];
    unique case (mem_addr_lo)
      2'd0: byte_sel = mem_rdata[31:24];
      2'd1: byte_sel = mem_rdata[23:16];
      2'd2: byte_sel = mem_rdata[15:8];
      2'd3: byte_sel = mem_rdata[7:0];
      default: byte_sel = mem_rdata[31:24];
    endcase
    half_sel = mem_addr_lo[1] ? mem_rdata[15:0] : mem_rdata[31:16];
  end

  always_comb begin
    aligned    = mem_wdata;
    misaligned = 1'b0;
    unique case (mem_load_op)
      OP_NONE: aligned = mem_wdata;
      OP_LB:   aligned = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
      OP_LBU:  aligned = {{(DATA_W-8){1'b0}}, byte_sel};
      OP_LH: begin
        aligned    = {{(DATA_W-16){half_sel[15]}}, half_sel};
        misaligned = mem_addr_lo[0];
      end
      OP_LHU: begin
        aligned    = {{(DATA_W-16){1'b0}}, half_sel};
        misaligned = mem_addr_lo[0];
      end
      OP_LW: begin
        aligned    = mem_rdata;
        misaligned = (mem_addr_lo != 2'd0);
      end
      OP_LWL: begin
        unique case (mem_addr_lo)
          2'd0: aligned = mem_rdata;
          2'd1: aligned = {mem_rdata[23:0], mem_rt_data[7:0]};
          2'd2: aligned = {mem_rdata[15:0], mem_rt_data[15:0]};
          2'd3: aligned = {mem_rdata[7:0], mem_rt_data[23:0]};
          default: aligned = mem_rdata;
        endcase
      end
      OP_LWR: begin
        unique case (mem_addr_lo)
          2'd0: aligned = {mem_rt_data[31:8], mem_rdata[31:24]};
          2'd1: aligned = {mem_rt_data[31:16], mem_rdata[31:16]};
          2'd2: aligned = {mem_rt_data[31:24], mem_rdata[31:8]};
          2'd3: aligned = mem_rdata;
          default: aligned = mem_rdata;
        endcase
      end
      default: aligned = mem_wdata;
    endcase
  end

  // Flush beats every stall; a held slot only survives when both stages stall.
  always_comb begin
    we_d    = we_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    mis_d   = mis_q;
    cnt_d   = cnt_q;
    if (flush || (mem_stall && !wb_stall)) begin
      we_d    = 1'b0;
      waddr_d = '0;
      wdata_d = '0;
      mis_d   = 1'b0;
    end else if (!mem_stall) begin
      we_d    = mem_valid & mem_we & ~misaligned;
      waddr_d = mem_waddr;
      wdata_d = aligned;
      mis_d   = mem_valid & misaligned;
      if (we_d) cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      mis_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      mis_q   <= mis_d;
      cnt_q   <= cnt_d;
    end
  end

  assign wb_we         = we_q;
  assign wb_waddr      = waddr_q;
  assign wb_wdata      = wdata_q;
  assign wb_misalign   = mis_q;
  assign wb_commit_cnt = cnt_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed, table-driven bench for mem_wb_stage: alignment, misalignment,
// stall/flush matrix, commit counter and asynchronous reset.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush, mem_stall, wb_stall, mem_valid, mem_we;
  logic [4:0]  mem_waddr;
  logic [31:0] mem_wdata, mem_rdata, mem_rt_data;
  logic [2:0]  mem_load_op;
  logic [1:0]  mem_addr_lo;
  logic        wb_we, wb_misalign;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata, wb_commit_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_wb_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .mem_stall(mem_stall), .wb_stall(wb_stall),
    .mem_valid(mem_valid), .mem_we(mem_we),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_load_op(mem_load_op), .mem_addr_lo(mem_addr_lo),
    .mem_rdata(mem_rdata), .mem_rt_data(mem_rt_data),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .wb_misalign(wb_misalign), .wb_commit_cnt(wb_commit_cnt)
  );

  typedef struct {
    logic        fl, ms, ws, v, we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [2:0]  op;
    logic [1:0]  lo;
    logic [31:0] rd, rt;
    logic        e_we;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
    logic        e_mis;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    logic fl, logic ms, logic ws, logic v, logic we,
    logic [4:0] wa, logic [31:0] wd, logic [2:0] op,
    logic [1:0] lo, logic [31:0] rd, logic [31:0] rt,
    logic e_we, logic [4:0] e_wa, logic [31:0] e_wd,
    logic e_mis, logic [31:0] e_cnt);
    vec_t r;
    r.fl = fl; r.ms = ms; r.ws = ws; r.v = v; r.we = we;
    r.wa = wa; r.wd = wd; r.op = op; r.lo = lo;
    r.rd = rd; r.rt = rt;
    r.e_we = e_we; r.e_wa = e_wa; r.e_wd = e_wd;
    r.e_mis = e_mis; r.e_cnt = e_cnt;
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(string tag, logic e_we, logic [4:0] e_wa,
                         logic [31:0] e_wd, logic e_mis,
                         logic [31:0] e_cnt);
    chk({tag, " we"}, {31'd0, wb_we}, {31'd0, e_we});
    chk({tag, " waddr"}, {27'd0, wb_waddr}, {27'd0, e_wa});
    chk({tag, " wdata"}, wb_wdata, e_wd);
    chk({tag, " misalign"}, {31'd0, wb_misalign}, {31'd0, e_mis});
    chk({tag, " cnt"}, wb_commit_cnt, e_cnt);
  endtask

  task automatic drive(vec_t t);
    flush = t.fl; mem_stall = t.ms; wb_stall = t.ws;
    mem_valid = t.v; mem_we = t.we; mem_waddr = t.wa;
    mem_wdata = t.wd; mem_load_op = t.op; mem_addr_lo = t.lo;
    mem_rdata = t.rd; mem_rt_data = t.rt;
  endtask

  task automatic write_op(logic [4:0] wa, logic [31:0] wd);
    drive(mk(0,0,0,1,1, wa, wd, 3'd0, 2'd0, 32'h0, 32'h0,
             0,0,0,0,0));
    @(posedge clk); #1;
  endtask

  initial begin
    // fl ms ws v we  wa  wdata  op lo  rdata  rt  | e_we e_wa e_wd mis cnt
    vecs.push_back(mk(0,0,0,1,1, 5'd3, 32'h0, 3'd1, 2'd1, 32'h12F45678, 32'h0,
                      1, 5'd3, 32'hFFFFFFF4, 0, 32'd1));
    vecs.push_back(mk(0,0,0,1,1, 5'd3, 32'h0, 3'd2, 2'd1, 32'h12F45678, 32'h0,
                      1, 5'd3, 32'h000000F4, 0, 32'd2));
    vecs.push_back(mk(0,0,0,1,1, 5'd4, 32'h0, 3'd6, 2'd1, 32'hAABBCCDD, 32'h11223344,
                      1, 5'd4, 32'hBBCCDD44, 0, 32'd3));
    vecs.push_back(mk(0,0,0,1,1, 5'd4, 32'h0, 3'd7, 2'd1, 32'hAABBCCDD, 32'h11223344,
                      1, 5'd4, 32'h1122AABB, 0, 32'd4));
    vecs.push_back(mk(0,0,0,1,1, 5'd4, 32'h0, 3'd7, 2'd3, 32'hAABBCCDD, 32'h11223344,
                      1, 5'd4, 32'hAABBCCDD, 0, 32'd5));
    vecs.push_back(mk(0,0,0,1,1, 5'd7, 32'h0, 3'd5, 2'd2, 32'hAABBCCDD, 32'h0,
                      0, 5'd7, 32'hAABBCCDD, 1, 32'd5));
    vecs.push_back(mk(0,0,0,1,1, 5'd8, 32'h0, 3'd3, 2'd2, 32'h12348001, 32'h0,
                      1, 5'd8, 32'hFFFF8001, 0, 32'd6));
    vecs.push_back(mk(0,0,0,1,1, 5'd8, 32'h0, 3'd4, 2'd0, 32'h80011234, 32'h0,
                      1, 5'd8, 32'h00008001, 0, 32'd7));
    vecs.push_back(mk(0,0,0,0,1, 5'd9, 32'h55, 3'd0, 2'd0, 32'h0, 32'h0,
                      0, 5'd9, 32'h00000055, 0, 32'd7));
    vecs.push_back(mk(0,0,0,1,1, 5'd0, 32'h0, 3'd5, 2'd0, 32'hDEADBEEF, 32'h0,
                      1, 5'd0, 32'hDEADBEEF, 0, 32'd8));
    vecs.push_back(mk(0,0,0,1,1, 5'd2, 32'h0, 3'd1, 2'd3, 32'h12F45680, 32'h0,
                      1, 5'd2, 32'hFFFFFF80, 0, 32'd9));
    vecs.push_back(mk(0,0,0,1,1, 5'd2, 32'h0, 3'd6, 2'd2, 32'hAABBCCDD, 32'h11223344,
                      1, 5'd2, 32'hCCDD3344, 0, 32'd10));
    vecs.push_back(mk(0,0,0,1,1, 5'd5, 32'h1234, 3'd0, 2'd0, 32'h0, 32'h0,
                      1, 5'd5, 32'h00001234, 0, 32'd11));
    // both stalled: hold for three cycles despite new input
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(0,1,1,1,1, 5'd6, 32'h9999, 3'd0, 2'd0, 32'h0, 32'h0,
                        1, 5'd5, 32'h00001234, 0, 32'd11));
    vecs.push_back(mk(0,1,0,1,1, 5'd6, 32'h9999, 3'd0, 2'd0, 32'h0, 32'h0,
                      0, 5'd0, 32'h0, 0, 32'd11));
    vecs.push_back(mk(0,0,0,1,1, 5'd5, 32'h1234, 3'd0, 2'd0, 32'h0, 32'h0,
                      1, 5'd5, 32'h00001234, 0, 32'd12));
    vecs.push_back(mk(1,1,1,1,1, 5'd6, 32'h9999, 3'd0, 2'd0, 32'h0, 32'h0,
                      0, 5'd0, 32'h0, 0, 32'd12));
    vecs.push_back(mk(1,0,0,1,1, 5'd6, 32'h9999, 3'd0, 2'd0, 32'h0, 32'h0,
                      0, 5'd0, 32'h0, 0, 32'd12));
    // misalign flag holds under double stall, then clears
    vecs.push_back(mk(0,0,0,1,1, 5'd10, 32'h0, 3'd4, 2'd3, 32'h11112222, 32'h0,
                      0, 5'd10, 32'h00002222, 1, 32'd12));
    vecs.push_back(mk(0,1,1,1,1, 5'd11, 32'h0, 3'd0, 2'd0, 32'h0, 32'h0,
                      0, 5'd10, 32'h00002222, 1, 32'd12));
    vecs.push_back(mk(0,0,0,0,0, 5'd11, 32'h77, 3'd0, 2'd0, 32'h0, 32'h0,
                      0, 5'd11, 32'h00000077, 0, 32'd12));

    rst = 1'b1;
    drive(mk(0,0,0,0,0, 5'd0, 32'h0, 3'd0, 2'd0, 32'h0, 32'h0,
             0,0,0,0,0));
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 0, 5'd0, 32'h0, 0, 32'd0);
    #2 rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i]);
      @(posedge clk); #1;
      chk_all($sformatf("vec%0d", i), vecs[i].e_we, vecs[i].e_wa,
              vecs[i].e_wd, vecs[i].e_mis, vecs[i].e_cnt);
    end

    // async reset mid-stream, between edges
    #2 rst = 1'b1;
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) write_op(5'(i + 1), 32'hA0 + 32'(i));
    chk_all("pre_rst", 1, 5'd4, 32'h000000A3, 0, 32'd4);
    #2 rst = 1'b1;
    #1;
    chk_all("async_rst", 0, 5'd0, 32'h0, 0, 32'd0);
    #1 rst = 1'b0;
    write_op(5'd12, 32'hCAFE);
    chk_all("post_rst", 1, 5'd12, 32'h0000CAFE, 0, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
